// File: rtl/change_dispenser.sv
// change_dispenser: pays owed change back out through a coin hopper.
// Each coffee event adds its balance (in 25p units) to a saturating owed
// counter. The FSM drives the hopper through a req/ack handshake, one coin
// per handshake. It enforces a low gap between coins, faults on an ack
// timeout, and keeps a sticky overflow flag.
// Optional feature macro: DISP_50_EN adds a 50p hopper (coin50_req/coin50_ack)
// that is used whenever at least two units are owed.
module change_dispenser #(
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coffee,
  input  logic [1:0]       balance,
  input  logic             coin_ack,
  input  logic             fault_clr,
  output logic             coin_req,
  output logic             busy,
  output logic [CNT_W-1:0] owed,
  output logic             done,
  output logic             fault,
  output logic             ovf
`ifdef DISP_50_EN
  ,
  input  logic             coin50_ack,
  output logic             coin50_req
`endif
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W+1:0] OWED_MAX = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_FAULT
  } state_t;

  state_t            state;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic              ack_seen;
  logic [1:0]        dec;
  logic [1:0]        add;
  logic [CNT_W+1:0]  sum;
  logic [CNT_W-1:0]  owed_next;
  logic              sat;
`ifdef DISP_50_EN
  logic              big;
  logic              start50;
`endif

  // Units paid this edge and the saturating owed update.
  always_comb begin
    ack_seen = 1'b0;
    dec      = 2'd0;
`ifdef DISP_50_EN
    start50  = (owed >= CNT_W'(2));
    if (state == S_REQ) begin
      if (big) begin
        ack_seen = coin50_ack;
        dec      = coin50_ack ? 2'd2 : 2'd0;
      end else begin
        ack_seen = coin_ack;
        dec      = coin_ack ? 2'd1 : 2'd0;
      end
    end
`else
    if (state == S_REQ) begin
      ack_seen = coin_ack;
      dec      = coin_ack ? 2'd1 : 2'd0;
    end
`endif
    add = coffee ? balance : 2'd0;
    sum = {2'b00, owed} + {{CNT_W{1'b0}}, add} - {{CNT_W{1'b0}}, dec};
    sat = (sum > OWED_MAX);
    owed_next = sat ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  // Dispense FSM with registered outputs; owed accumulates in every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      gap_cnt  <= '0;
      owed     <= '0;
      coin_req <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      ovf      <= 1'b0;
`ifdef DISP_50_EN
      coin50_req <= 1'b0;
      big        <= 1'b0;
`endif
    end else begin
      owed <= owed_next;
      if (sat) ovf <= 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (owed != '0) begin
            state <= S_REQ;
            busy  <= 1'b1;
            timer <= '0;
`ifdef DISP_50_EN
            big        <= start50;
            coin50_req <= start50;
            coin_req   <= !start50;
`else
            coin_req <= 1'b1;
`endif
          end
        end
        S_REQ: begin
          if (ack_seen) begin
            coin_req <= 1'b0;
`ifdef DISP_50_EN
            coin50_req <= 1'b0;
`endif
            timer   <= '0;
            gap_cnt <= GW'(GAP_CYCLES);
            state   <= S_GAP;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            coin_req <= 1'b0;
`ifdef DISP_50_EN
            coin50_req <= 1'b0;
`endif
            timer <= '0;
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_GAP: begin
          // Leaving on the cycle the count would hit 0 keeps the request
          // low for exactly GAP_CYCLES cycles.
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            if (owed != '0) begin
              state <= S_REQ;
              timer <= '0;
`ifdef DISP_50_EN
              big        <= start50;
              coin50_req <= start50;
              coin_req   <= !start50;
`else
              coin_req <= 1'b1;
`endif
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        S_FAULT: begin
          if (fault_clr) begin
            fault <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Return path of the coffee vending machine. The vending FSM consumes coins through the money code; this block pays change back out.
- Accumulates change owed from each coffee event (coffee pulse plus balance code, in 25p units).
- Drives a coin-hopper actuator through a req/ack handshake, one coin per handshake.
- Sits between the vending FSM outputs and the hopper driver. Provides timeout fault detection and a sticky overflow flag.

Parameters:
- CNT_W, 4, width of the owed-change accumulator in 25p units (max owed = 2^CNT_W-1).
- TIMEOUT_CYCLES, 16, REQ cycles without ack before FAULT (>=2).
- GAP_CYCLES, 2, cycles coin_req is held low between coins (>=1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset; sampled on rising clk.
- coffee  in  1  one-cycle pulse from vending FSM: coffee vended, balance valid this cycle.
- balance  in  2  change owed with this coffee: 00=0, 01=25p, 10=50p, 11=75p (value = count of 25p units).
- coin_ack  in  1  hopper: one 25p coin ejected (level or pulse; sampled only in REQ).
- fault_clr  in  1  clears FAULT and returns to IDLE.
- coin_req  out  1  request hopper to eject one 25p coin.
- busy  out  1  high whenever state != IDLE.
- owed  out  CNT_W  current change still to pay, in 25p units.
- done  out  1  one-cycle pulse: owed reached 0 after dispensing.
- fault  out  1  hopper timeout; high while in FAULT.
- ovf  out  1  sticky: accumulator saturated; cleared only by reset.
- coin50_req / coin50_ack  out/in  1  present only with DISP_50_EN.

Behaviour:
- Reset (rst==0 at edge): state=IDLE; coin_req=0, busy=0, owed=0, done=0, fault=0, ovf=0, timers=0. Reset mid-handshake drops coin_req on the next edge. Owed change is lost.
- All outputs registered.
- Accumulate on every edge with coffee=1, in any state including FAULT:
  - owed_next = owed + balance - dec. dec = units paid this edge (0, 1, or 2).
  - Saturate at 2^CNT_W-1 and set ovf.
  - balance is ignored when coffee=0.
- FSM states IDLE, REQ, GAP, FAULT:
  - IDLE: if owed!=0 (registered value), go to REQ next edge. coin_req=0.
  - REQ: coin_req=1; the timeout counter increments each cycle.
    - coin_ack=1 sampled: dec=1, clear the timer, load the gap counter with GAP_CYCLES, go to GAP.
    - Timer reaches TIMEOUT_CYCLES-1 with no ack: go to FAULT and drop coin_req.
  - GAP: coin_req=0. Count down. At 0: go to REQ if owed!=0, else go to IDLE and pulse done for one cycle, coincident with busy falling.
  - FAULT: fault=1, coin_req=0. Accumulation continues. fault_clr=1 goes to IDLE and keeps owed; IDLE then re-enters REQ if owed!=0.
- Latency: coffee with balance!=0 sampled at edge k gives owed updated after k and coin_req=1 after edge k+1.
- Simultaneous coffee and coin_ack at the same edge: both apply (owed + balance - 1). No event is lost.
- A coffee arriving during GAP or REQ extends the current dispense run. done fires only at the true end.
- coin_ack outside REQ is ignored.
- A coin_ack held high for multiple cycles counts once, because REQ is left on the first ack.

Optional Feature:
- Macro DISP_50_EN.
- Defined: ports coin50_req/coin50_ack exist.
  - On entering REQ with owed>=2, assert coin50_req instead of coin_req. coin50_ack gives dec=2.
  - With owed==1, use coin_req. Only one request is high at a time.
  - Timeout, gap and fault rules are identical for both hoppers.
- Not defined: ports absent; all change is paid in 25p coins.

Test Plan:
- Reset: hold rst=0 for 2 cycles with coffee=1, balance=11 -> all outputs 0, owed=0. Release -> IDLE, no coin_req.
- Single 75p: coffee pulse with balance=11, ack each request after 1 cycle -> owed goes 3,2,1,0. Exactly 3 coin_req pulses separated by >=2 low cycles. done pulses once, busy falls with it.
- Merge: balance=10 coffee, then balance=01 coffee on the same edge as the first coin_ack -> owed goes 2, 2, ... with 3 coins total and one done.
- Timeout: balance=01, never ack -> coin_req high for 16 cycles, then fault=1, coin_req=0, owed=1. Pulse fault_clr -> REQ again. Ack -> done.
- Overflow: six coffees with balance=11 and no ack -> owed saturates at 15, ovf=1 and stays set after owed drains to 0.
- DISP_50_EN: balance=11 -> one coin50_req (owed 3->1), then one coin_req (1->0), then done. Never both requests high together.
